// File: rtl/acc_cpu_control_pkg.sv
// Shared encodings for the accumulator CPU controller: opcodes, ALU selects, FSM states.
package acc_cpu_pkg;

  typedef enum logic [3:0] {
    OP_HALT  = 4'h0,
    OP_LOAD  = 4'h1,
    OP_STORE = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_AND   = 4'h5,
    OP_OR    = 4'h6,
    OP_JMP   = 4'h7,
    OP_JZ    = 4'h8
  } opcode_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [15:0] RESET_PC_DEF = 16'h0100;

  typedef logic [2:0] state_t;
  localparam state_t S_FETCH      = 3'd0;
  localparam state_t S_FETCH_WAIT = 3'd1;
  localparam state_t S_DECODE     = 3'd2;
  localparam state_t S_READ       = 3'd3;
  localparam state_t S_READ_WAIT  = 3'd4;
  localparam state_t S_EXEC       = 3'd5;
  localparam state_t S_WRITE      = 3'd6;
  localparam state_t S_HALT       = 3'd7;

endpackage

// File: rtl/acc_cpu_control_if.sv
// RAM and ALU connections of the controller; master = controller, slave = RAM/ALU side.
interface acc_cpu_control_if #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [1:0]            alu_sel;
  logic [DATA_WIDTH-1:0] alu_out;

  modport master (
    output mem_addr, mem_cs, mem_we, mem_oe, mem_wdata, alu_a, alu_b, alu_sel,
    input  mem_rdata, alu_out
  );

  modport slave (
    input  mem_addr, mem_cs, mem_we, mem_oe, mem_wdata, alu_a, alu_b, alu_sel,
    output mem_rdata, alu_out
  );
endinterface

// File: rtl/acc_cpu_control.sv
// Fetch/decode/execute FSM for the 16-bit accumulator CPU; owns PC/IR/MBR/AC.
// One state per clock; RAM reads return one cycle after the request.
module acc_cpu_control
  import acc_cpu_pkg::*;
#(
  parameter int          ADDR_WIDTH = 18,
  parameter int          DATA_WIDTH = 16,
  parameter logic [15:0] RESET_PC   = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  acc_cpu_control_if.master     bus,
  output logic                  halted,
  output logic [15:0]           dbg_pc,
  output logic [DATA_WIDTH-1:0] dbg_ac
);

  state_t                state;
  logic [15:0]           pc;
  logic [DATA_WIDTH-1:0] ir;
  logic [DATA_WIDTH-1:0] mbr;
  logic [DATA_WIDTH-1:0] ac;

  logic [3:0]            opcode;
  logic [15:0]           operand_pc;
  logic [ADDR_WIDTH-1:0] ea;

  assign opcode     = ir[15:12];
  assign operand_pc = {4'h0, ir[11:0]};
  assign ea         = {{(ADDR_WIDTH-12){1'b0}}, ir[11:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      mbr   <= '0;
      ac    <= '0;
    end else begin
      case (state)
        S_FETCH:      state <= S_FETCH_WAIT;
        S_FETCH_WAIT: begin
          ir    <= bus.mem_rdata;
          pc    <= pc + 16'd1;
          state <= S_DECODE;
        end
        S_DECODE: begin
          state <= S_FETCH;
          case (opcode)
            OP_HALT:                             state <= S_HALT;
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR: state <= S_READ;
            OP_STORE:                            state <= S_WRITE;
            OP_JMP:                              pc <= operand_pc;
            OP_JZ:   if (ac == '0)               pc <= operand_pc;
            default: ;
          endcase
        end
        S_READ:       state <= S_READ_WAIT;
        S_READ_WAIT: begin
          mbr   <= bus.mem_rdata;
          state <= S_EXEC;
        end
        // Only LOAD and the four ALU ops reach EXEC.
        S_EXEC: begin
          if (opcode == OP_LOAD) ac <= mbr;
          else                   ac <= bus.alu_out;
          state <= S_FETCH;
        end
        S_WRITE: state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Strobes are gated by rst so an in-flight write is dropped the moment reset rises.
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_cs   = 1'b0;
    bus.mem_we   = 1'b0;
    bus.mem_oe   = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          bus.mem_addr = ADDR_WIDTH'(pc);
          bus.mem_cs   = 1'b1;
          bus.mem_oe   = 1'b1;
        end
        S_READ: begin
          bus.mem_addr = ea;
          bus.mem_cs   = 1'b1;
          bus.mem_oe   = 1'b1;
        end
        S_WRITE: begin
          bus.mem_addr = ea;
          bus.mem_cs   = 1'b1;
          bus.mem_we   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (opcode)
      OP_SUB:  bus.alu_sel = ALU_SUB;
      OP_AND:  bus.alu_sel = ALU_AND;
      OP_OR:   bus.alu_sel = ALU_OR;
      default: bus.alu_sel = ALU_ADD;
    endcase
  end

  assign bus.mem_wdata = ac;
  assign bus.alu_a     = ac;
  assign bus.alu_b     = mbr;
  assign halted        = (state == S_HALT);
  assign dbg_pc        = pc;
  assign dbg_ac        = ac;

endmodule

// File: tb/tb_acc_cpu_control.sv
// Bench for acc_cpu_control: bench-owned RAM/ALU plus an instruction-level model expanded to a bus trace.
`timescale 1ns/1ps
module tb_acc_cpu_control;
  import acc_cpu_pkg::*;

  localparam int AW = 18;
  localparam int DW = 16;

  typedef struct packed {
    logic          cs;
    logic          we;
    logic          oe;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic          halted;
    logic [15:0]   pc;
    logic [15:0]   ac;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        halted;
  logic [15:0] dbg_pc;
  logic [15:0] dbg_ac;

  acc_cpu_control_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  acc_cpu_control #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(16'h0100)) dut (
    .clk(clk), .rst(rst), .bus(bus), .halted(halted), .dbg_pc(dbg_pc), .dbg_ac(dbg_ac)
  );

  always #5 clk = ~clk;

  logic [15:0] ram   [0:4095];
  logic [15:0] image [0:4095];
  logic        load_req = 1'b0;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < 4096; i++) ram[i] <= image[i];
    end else if (bus.mem_cs && bus.mem_we) begin
      ram[bus.mem_addr[11:0]] <= bus.mem_wdata;
    end
    if (bus.mem_cs && !bus.mem_we && bus.mem_oe) bus.mem_rdata <= ram[bus.mem_addr[11:0]];
  end

  always_comb begin
    case (bus.alu_sel)
      2'b00:   bus.alu_out = bus.alu_a + bus.alu_b;
      2'b01:   bus.alu_out = bus.alu_a - bus.alu_b;
      2'b10:   bus.alu_out = bus.alu_a & bus.alu_b;
      default: bus.alu_out = bus.alu_a | bus.alu_b;
    endcase
  end

  int          tests = 0;
  int          fails = 0;
  cyc_t        expq[$];
  logic [15:0] mm [0:4095];
  logic [15:0] m_ac;
  bit          m_ok;
  int          first_halt;
  int          wcnt;
  logic [15:0] wlast;
  logic [AW-1:0] watch;
  bit          aborted;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic cyc_t rec(input logic cs, input logic we, input logic oe,
                               input logic [AW-1:0] a, input logic [15:0] ac,
                               input logic h, input logic [15:0] pc);
    cyc_t r;
    r.cs = cs; r.we = we; r.oe = oe; r.addr = a; r.wdata = ac;
    r.halted = h; r.pc = pc; r.ac = ac;
    return r;
  endfunction

  // Interprets the program instruction by instruction and expands each into its bus cycles.
  task automatic build_model();
    logic [15:0] pc, ac, ir, npc, m;
    logic [11:0] ea;
    logic [3:0]  op;
    bit          done;
    for (int i = 0; i < 4096; i++) mm[i] = image[i];
    expq.delete();
    pc = 16'h0100; ac = 16'h0; done = 1'b0; m_ok = 1'b0;
    for (int s = 0; s < 4000 && !done; s++) begin
      ir = mm[pc[11:0]]; op = ir[15:12]; ea = ir[11:0]; npc = pc + 16'd1;
      expq.push_back(rec(1'b1, 1'b0, 1'b1, AW'(pc), ac, 1'b0, pc));
      expq.push_back(rec(1'b0, 1'b0, 1'b0, '0, ac, 1'b0, pc));
      expq.push_back(rec(1'b0, 1'b0, 1'b0, '0, ac, 1'b0, npc));
      pc = npc;
      case (op)
        4'h0: begin
          repeat (3) expq.push_back(rec(1'b0, 1'b0, 1'b0, '0, ac, 1'b1, npc));
          done = 1'b1; m_ok = 1'b1;
        end
        4'h1, 4'h3, 4'h4, 4'h5, 4'h6: begin
          expq.push_back(rec(1'b1, 1'b0, 1'b1, AW'(ea), ac, 1'b0, npc));
          expq.push_back(rec(1'b0, 1'b0, 1'b0, '0, ac, 1'b0, npc));
          expq.push_back(rec(1'b0, 1'b0, 1'b0, '0, ac, 1'b0, npc));
          m = mm[ea];
          case (op)
            4'h1:    ac = m;
            4'h3:    ac = ac + m;
            4'h4:    ac = ac - m;
            4'h5:    ac = ac & m;
            default: ac = ac | m;
          endcase
        end
        4'h2: begin
          expq.push_back(rec(1'b1, 1'b1, 1'b0, AW'(ea), ac, 1'b0, npc));
          mm[ea] = ac;
        end
        4'h7: pc = {4'h0, ea};
        4'h8: if (ac == 16'h0) pc = {4'h0, ea};
        default: ;
      endcase
    end
    m_ac = ac;
  endtask

  task automatic run(input string name, input bit do_load, input bit abort_wr);
    cyc_t o, e;
    rst = 1'b1;
    aborted = 1'b0;
    if (do_load) begin
      @(negedge clk); load_req = 1'b1;
      @(negedge clk); load_req = 1'b0;
    end
    build_model();
    if (!m_ok) begin
      tests++; fails++;
      $display("FAIL %s model: no HALT within step budget", name);
    end
    first_halt = -1; wcnt = 0; wlast = 16'h0;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < expq.size(); i++) begin
      if (i > 0) @(negedge clk);
      #1;
      o.cs = bus.mem_cs; o.we = bus.mem_we; o.oe = bus.mem_oe; o.addr = bus.mem_addr;
      o.wdata = bus.mem_wdata; o.halted = halted; o.pc = dbg_pc; o.ac = dbg_ac;
      e = expq[i];
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s cycle %0d: got cs%b we%b oe%b addr=%h wd=%h h%b pc=%h ac=%h expected cs%b we%b oe%b addr=%h wd=%h h%b pc=%h ac=%h",
                 name, i, o.cs, o.we, o.oe, o.addr, o.wdata, o.halted, o.pc, o.ac,
                 e.cs, e.we, e.oe, e.addr, e.wdata, e.halted, e.pc, e.ac);
      end
      if (o.halted && first_halt < 0) first_halt = i;
      if (o.cs && o.we && o.addr == watch) begin wcnt++; wlast = o.wdata; end
      if (abort_wr && o.cs && o.we) begin
        rst = 1'b1; aborted = 1'b1;
        return;
      end
    end
  endtask

  task automatic clear_image();
    for (int i = 0; i < 4096; i++) image[i] = 16'h0;
  endtask

  task automatic load_fib();
    logic [15:0] prog [0:14];
    prog = '{16'h1212, 16'h810C, 16'h4213, 16'h2212, 16'h1210, 16'h3211, 16'h2214, 16'h1211,
             16'h2210, 16'h1214, 16'h2211, 16'h7100, 16'h1210, 16'h2215, 16'h0000};
    clear_image();
    for (int i = 0; i < 15; i++) image[12'h100 + i] = prog[i];
    image[12'h210] = 16'h0000; image[12'h211] = 16'h0001;
    image[12'h212] = 16'h000B; image[12'h213] = 16'h0001;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int len, k;
    logic [3:0]  op;
    logic [11:0] opnd;
    watch = '0;

    // LOAD then HALT
    clear_image();
    image[12'h100] = 16'h1200; image[12'h101] = 16'h0000; image[12'h200] = 16'h0005;
    run("t2_load", 1'b1, 1'b0);
    chk("t2_halt_cycle", 32'(first_halt), 32'd9);
    chk("t2_ac", 32'(dbg_ac), 32'h0005);
    chk("t2_halted", 32'(halted), 32'd1);

    // asynchronous reset away from any clock edge
    @(negedge clk); #2; rst = 1'b1; #1;
    chk("t1_cs", 32'(bus.mem_cs), 32'd0);
    chk("t1_we_oe", 32'({bus.mem_we, bus.mem_oe}), 32'd0);
    chk("t1_addr", 32'(bus.mem_addr), 32'd0);
    chk("t1_halted", 32'(halted), 32'd0);
    chk("t1_pc", 32'(dbg_pc), 32'h0100);
    chk("t1_ac", 32'(dbg_ac), 32'h0000);

    // ALU ops including SUB wrap
    clear_image();
    image[12'h100] = 16'h1200; image[12'h101] = 16'h3201; image[12'h102] = 16'h4202;
    image[12'h103] = 16'h5203; image[12'h104] = 16'h0000;
    image[12'h200] = 16'h0005; image[12'h201] = 16'h0003;
    image[12'h202] = 16'h000A; image[12'h203] = 16'h00F0;
    run("t3_alu", 1'b1, 1'b0);
    chk("t3_model_ac", 32'(m_ac), 32'h00F0);
    chk("t3_ac", 32'(dbg_ac), 32'h00F0);

    // single STORE cycle
    clear_image();
    image[12'h100] = 16'h1204; image[12'h101] = 16'h2300; image[12'h102] = 16'h0000;
    image[12'h204] = 16'h1234;
    watch = AW'(12'h300);
    run("t4_store", 1'b1, 1'b0);
    chk("t4_write_cycles", 32'(wcnt), 32'd1);
    chk("t4_wdata", 32'(wlast), 32'h1234);
    chk("t4_ram", 32'(ram[12'h300]), 32'h1234);
    watch = '0;

    // Fibonacci loop
    load_fib();
    run("t5_fib", 1'b1, 1'b0);
    chk("t5_model_result", 32'(mm[12'h215]), 32'h0059);
    chk("t5_ram_result", 32'(ram[12'h215]), 32'h0059);
    chk("t5_halted", 32'(halted), 32'd1);

    // reset during the first write, then rerun
    load_fib();
    run("t6_abort", 1'b1, 1'b1);
    chk("t6_aborted", 32'(aborted), 32'd1);
    #1;
    chk("t6_we_drop", 32'(bus.mem_we), 32'd0);
    repeat (2) @(negedge clk);
    chk("t6_ram_untouched", 32'(ram[12'h212]), 32'h000B);
    chk("t6_pc", 32'(dbg_pc), 32'h0100);
    run("t6_rerun", 1'b0, 1'b0);
    chk("t6_result", 32'(ram[12'h215]), 32'h0059);

    // random forward-branching programs
    for (int r = 0; r < 8; r++) begin
      clear_image();
      len = $urandom_range(8, 20);
      for (int i = 0; i < len; i++) begin
        k = $urandom_range(0, 11);
        case (k)
          0, 9:    op = 4'h1;
          1, 11:   op = 4'h2;
          2:       op = 4'h3;
          3:       op = 4'h4;
          4:       op = 4'h5;
          5:       op = 4'h6;
          6:       op = 4'h7;
          7, 10:   op = 4'h8;
          default: op = 4'($urandom_range(9, 15));
        endcase
        if (op == 4'h7 || op == 4'h8) opnd = 12'(32'h100 + $urandom_range(i + 1, len));
        else                          opnd = 12'(32'h200 + $urandom_range(0, 15));
        image[12'(32'h100 + i)] = {op, opnd};
      end
      for (int j = 0; j < 16; j++)
        image[12'(32'h200 + j)] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      run($sformatf("rand%0d", r), 1'b1, 1'b0);
      for (int j = 0; j < 16; j++)
        chk($sformatf("rand%0d_mem%0d", r, j), 32'(ram[12'(32'h200 + j)]), 32'(mm[12'(32'h200 + j)]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
